// File: rtl/muldiv_pkg.sv
// Shared M-extension decode constants, op encoding and FSM states
// for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    // Funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle between the datapath (master)
// and the multiply/divide unit (slave).
interface muldiv_if #(parameter int XLEN = 32);

    logic            valid_i;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            flush_i;
    logic            is_muldiv_o;
    logic            ready_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, ALUOp, Funct7, Funct3, SrcA, SrcB, flush_i,
        input  is_muldiv_o, ready_o, busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, ALUOp, Funct7, Funct3, SrcA, SrcB, flush_i,
        output is_muldiv_o, ready_o, busy_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_decode.sv
// Combinational decode of the M-extension fields: op, operand signedness
// and the divide-by-zero / signed-overflow shortcuts.
module muldiv_decode
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            is_muldiv,
    output muldiv_op_e      op,
    output logic            signed_a,
    output logic            signed_b,
    output logic            div0,
    output logic            ovf
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        is_muldiv = (alu_op == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);
        op        = muldiv_op_e'(funct3);
        signed_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        div0      = is_div(op) && (src_b == '0);
        // Only the signed divide group can overflow: MIN_INT / -1.
        ovf       = is_div(op) && signed_b && (src_a == MIN_INT) && (src_b == '1);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle over a
// 2*XLEN accumulator, with a one-cycle done pulse and registered result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_p_q, neg_p_d;
    logic              neg_r_q, neg_r_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              dec_is_muldiv, dec_signed_a, dec_signed_b, dec_div0, dec_ovf;
    muldiv_op_e        dec_op;

    logic              a_neg, b_neg, accept;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     add_sum, rem_sh;
    logic              fits;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    muldiv_decode #(.XLEN(XLEN)) u_decode (
        .alu_op    (bus.ALUOp),
        .funct7    (bus.Funct7),
        .funct3    (bus.Funct3),
        .src_a     (bus.SrcA),
        .src_b     (bus.SrcB),
        .is_muldiv (dec_is_muldiv),
        .op        (dec_op),
        .signed_a  (dec_signed_a),
        .signed_b  (dec_signed_b),
        .div0      (dec_div0),
        .ovf       (dec_ovf)
    );

    // Operand magnitudes, one iteration step and the sign-corrected result.
    always_comb begin
        a_neg  = dec_signed_a && bus.SrcA[XLEN-1];
        b_neg  = dec_signed_b && bus.SrcB[XLEN-1];
        a_mag  = a_neg ? -bus.SrcA : bus.SrcA;
        b_mag  = b_neg ? -bus.SrcB : bus.SrcB;
        accept = (state_q == IDLE) && bus.valid_i && dec_is_muldiv && !bus.flush_i;

        if (dec_op[1]) special_res = dec_div0 ? bus.SrcA : '0;
        else           special_res = dec_div0 ? '1 : bus.SrcA;

        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        fits    = rem_sh >= {1'b0, opnd_q};
        // The difference is always below the divisor, so XLEN bits suffice.
        rem_new = fits ? (rem_sh[XLEN-1:0] - opnd_q) : rem_sh[XLEN-1:0];

        if (is_div(op_q)) step = {rem_new, acc_q[XLEN-2:0], fits};
        else              step = {add_sum, acc_q[XLEN-1:1]};

        prod = neg_p_q ? -step : step;
        quo  = neg_p_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = neg_r_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                        final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = quo;
            default:                       final_res = rem;
        endcase
    end

    // Next-state logic; done_d and result_d are loaded on entry to DONE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = dec_op;
                    neg_p_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    if (dec_div0 || dec_ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                        done_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN);
                        opnd_d  = is_div(dec_op) ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div(dec_op) ? a_mag : b_mag)};
                    end
                end
            end
            CALC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.is_muldiv_o = dec_is_muldiv;
    assign bus.ready_o     = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE) && !done_q;
    assign bus.done_o      = done_q;
    assign bus.result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32) with hand-computed expectations.
module tb_muldiv_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, then reports the cycle index (1 = just after the
    // accepting edge) at which done_o appeared, the result and busy count.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res, output int busy_cycles);
        int idx;
        bus.valid_i = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.Funct7  = 7'b0000001;
        bus.Funct3  = f3;
        bus.SrcA    = a;
        bus.SrcB    = b;
        tick();
        bus.valid_i = 1'b0;
        idx = 1;
        busy_cycles = 0;
        while (!bus.done_o && idx < 100) begin
            if (bus.busy_o) busy_cycles++;
            tick();
            idx++;
        end
        lat = bus.done_o ? idx : -1;
        res = bus.result_o;
    endtask

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        int          busy_cycles;
        logic [31:0] res;
        checkOutput({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        applyStimulus(f3, a, b, lat, res, busy_cycles);
        checkOutput({tag, "_result"}, res, exp_res);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
        checkOutput({tag, "_result_held"}, bus.result_o, exp_res);
    endtask

    // Flags any done pulse over a window where none may occur.
    task automatic expectNoDone(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done_o) seen++;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.valid_i  = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.Funct7   = 7'b0;
        bus.Funct3   = 3'b0;
        bus.SrcA     = '0;
        bus.SrcB     = '0;
        bus.flush_i  = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_done", 32'(bus.done_o), 32'd0);
        checkOutput("reset_result", bus.result_o, 32'd0);
        reset_n = 1'b1;
        tick();

        runOp("mul_7xm3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);

        // Flush in CALC: back to IDLE, no done, result untouched.
        bus.valid_i = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.Funct7  = 7'b0000001;
        bus.Funct3  = 3'b000;
        bus.SrcA    = 32'd3;
        bus.SrcB    = 32'd5;
        tick();
        bus.valid_i = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        checkOutput("flush_busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("flush_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("flush_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("flush_done", 32'(bus.done_o), 32'd0);
        checkOutput("flush_result", bus.result_o, 32'hFFFFFFEB);
        runOp("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 33);

        runOp("mulhu_ffxff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("mulh_m1xm1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        runOp("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        runOp("mul_big",     3'b000, 32'h00012345, 32'h00010000, 32'h23450000, 33);
        runOp("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        runOp("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        runOp("div_100_m7",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        runOp("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33);
        runOp("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33);
        runOp("divu_by0",    3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1);
        runOp("rem_by0",     3'b110, 32'h00001234, 32'd0,        32'h00001234, 1);
        runOp("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        runOp("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Non-M instruction: decoded out, unit stays idle.
        bus.valid_i = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.Funct7  = 7'b0000000;
        bus.Funct3  = 3'b000;
        bus.SrcA    = 32'd9;
        bus.SrcB    = 32'd9;
        #1;
        checkOutput("nonm_is_muldiv", 32'(bus.is_muldiv_o), 32'd0);
        expectNoDone("nonm_no_done", 5);
        checkOutput("nonm_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("nonm_result", bus.result_o, 32'd0);
        bus.valid_i = 1'b0;

        // Reset in the middle of CALC.
        bus.valid_i = 1'b1;
        bus.Funct7  = 7'b0000001;
        tick();
        bus.valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("midrst_busy_before", 32'(bus.busy_o), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("midrst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("midrst_done", 32'(bus.done_o), 32'd0);
        checkOutput("midrst_result", bus.result_o, 32'd0);
        tick();
        reset_n = 1'b1;
        expectNoDone("midrst_no_done", 40);
        runOp("mul_after_reset", 3'b000, 32'd9, 32'd9, 32'd81, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit, parametrised in XLEN. It decodes the M-extension (ALUOp=10, Funct7=0000001) from the same ALUOp/Funct7/Funct3 fields used by the ALU controller. It runs one bit per cycle and signals completion with a valid/ready/done handshake so the datapath can stall. It sits beside the ALU in EX; the hazard unit uses busy_o to freeze the pipeline.

Parameters:
XLEN, 32, operand/result width (32 or 64).
CNT_W, $clog2(XLEN)+1, iteration counter width (localparam, derived).

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_i  in  1  EX-stage instruction valid
ALUOp  in  2  controller op class (10 = R/I-type)
Funct7  in  7  instruction bits 31:25
Funct3  in  3  instruction bits 14:12
SrcA  in  XLEN  rs1 operand
SrcB  in  XLEN  rs2 operand
flush_i  in  1  abort in-flight op (branch/trap)
is_muldiv_o  out  1  combinational: ALUOp==10 && Funct7==0000001
ready_o  out  1  unit idle, can accept
busy_o  out  1  operation accepted and not yet done
done_o  out  1  one-cycle result-valid pulse
result_o  out  XLEN  result, held until next accept

Behaviour:
- Reset (async, reset_n=0): state IDLE, done_o=0, busy_o=0, result_o=0, counter=0, internal regs=0.
- States: IDLE, CALC, DONE. ready_o = (state==IDLE); busy_o = (state!=IDLE && !done_o), i.e. high in CALC only.
- Accept: in IDLE when valid_i && is_muldiv_o && !flush_i. Latch op, operand magnitudes, sign flags; counter=XLEN; go to CALC. Requests made in CALC or DONE are ignored.
- Funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Signed ops use absolute values. MULH: both operands signed. MULHSU: SrcA signed, SrcB unsigned. DIV/REM: both signed.
- Multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
- Divide: restoring divide, one quotient bit per cycle.
- Counter decrements each CALC cycle; at counter==1, next state is DONE.
- DONE, entered after XLEN CALC cycles:
  - Apply sign correction. Product is negated (2*XLEN-bit two's complement) if the operand signs differ (MULHSU: if SrcA<0). Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - result_o is registered, done_o=1 for exactly one cycle, then IDLE.
- Latency: accept at edge T; done_o high in cycle T+XLEN+1. Throughput is one op per XLEN+2 cycles.
- Divide by zero (SrcB==0, DIV*/REM*): skip CALC, IDLE->DONE directly (done at T+1). DIV/DIVU return all-ones; REM/REMU return SrcA.
- Signed overflow (DIV/REM, SrcA=-2^(XLEN-1), SrcB=-1): skip CALC, done at T+1. DIV returns SrcA; REM returns 0.
- Zero-cycle shortcut for either multiplicand being 0: not implemented; full latency applies.
- flush_i in CALC or DONE: next state IDLE. done_o is suppressed (0 in the following cycle), result_o is unchanged.
- flush_i has priority over accept in the same cycle.
- Non-M instructions (is_muldiv_o=0): no state change, outputs hold.
- Mid-operation reset: immediate return to IDLE with reset values; no done pulse after release.

Decomposition:
- Package muldiv_pkg holds:
  - FUNCT7_MULDIV=7'b0000001 and ALUOP_RTYPE=2'b10.
  - muldiv_op_e enum over the Funct3 codes.
  - muldiv_state_e {IDLE, CALC, DONE}.
  - helper function is_div(op).
- One natural sub-module: muldiv_decode (combinational). It produces is_muldiv, op enum, signed_a/signed_b and the special-case flags (div0, ovf). The core muldiv_unit holds the FSM and datapath.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD (-3), XLEN=32 -> done_o at T+33, result_o=0xFFFFFFEB; busy_o high for 32 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF with done at T+1; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Accept MUL, assert flush_i at cycle T+10 -> IDLE next cycle, no done_o, result_o unchanged; new op accepted the cycle after.
- ALUOp=10, Funct7=0000000 with valid_i -> is_muldiv_o=0, ready_o stays 1, no done_o; reset_n low mid-CALC -> outputs at reset values immediately.
